// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: in-order word reads over req/gnt+rvalid, small instruction FIFO, redirect flush.
// Define IFU_PERF_CNT_EN to add the perf_bubble_cnt / perf_flush_cnt counter ports.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [4:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic        id_illegal
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_bubble_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           hold_q, hold_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    resp_pc_q, resp_pc_d;
    logic [CW-1:0]  outstanding_q, outstanding_d;
    logic [CW-1:0]  discard_q, discard_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [31:0]    fifo_inst_q [FIFO_DEPTH];
    logic [31:0]    fifo_inst_d [FIFO_DEPTH];
    logic [31:0]    fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]    fifo_pc_d   [FIFO_DEPTH];

    logic gnt_fire;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // hold_q keeps the request low for one cycle after reset release and after a redirect
    assign imem_req  = (state_q == RUN) && !hold_q && ((outstanding_q + count_q) < CW'(FIFO_DEPTH));
    assign imem_addr = addr_q;
    assign gnt_fire  = imem_req && imem_gnt;
    assign push      = (state_q == RUN) && imem_rvalid && !redirect_valid;
    assign id_valid  = (count_q != '0) && !redirect_valid;
    assign pop       = id_valid && id_ready;

    assign id_inst    = fifo_inst_q[rd_ptr_q];
    assign id_pc      = fifo_pc_q[rd_ptr_q];
    assign id_opcode  = id_inst[6:2];
    assign id_funct3  = id_inst[14:12];
    assign id_funct7  = id_inst[31:25];
    assign id_illegal = id_valid && (id_inst[1:0] != 2'b11);

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        addr_d        = addr_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_inst_d   = fifo_inst_q;
        fifo_pc_d     = fifo_pc_q;

        if (redirect_valid) begin
            // every read still in flight, including one granted right now, becomes a discard
            addr_d        = {redirect_pc[31:2], 2'b00};
            resp_pc_d     = {redirect_pc[31:2], 2'b00};
            hold_d        = 1'b1;
            discard_d     = discard_q + outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid);
            outstanding_d = '0;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end else begin
            hold_d = 1'b0;
            if (gnt_fire) begin
                addr_d = addr_q + 32'd4;
            end
            if (state_q == DRAIN) begin
                if (imem_rvalid) begin
                    discard_d = discard_q - CW'(1);
                end
            end else begin
                outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(imem_rvalid);
            end
            if (push) begin
                fifo_inst_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
                resp_pc_d             = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end

        state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            hold_q        <= 1'b1;
            addr_q        <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            addr_q        <= addr_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_inst_q   <= fifo_inst_d;
            fifo_pc_q     <= fifo_pc_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // both counters saturate at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (id_ready && !id_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (redirect_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule
